tournament_chooser: RTL and testbench

- Parametrised chooser table for a tournament branch predictor: a table of saturating counters that selects predictor 1 or predictor 2 per branch.
- Generalises the fixed 4096x2-bit chooser:
  - configurable depth and counter width;
  - optional global-history XOR index hashing;
  - registered lookup with same-cycle update bypass;
  - clocked, conflict-free updates;
  - hardware table-initialisation sweep after reset.
- Sits in the fetch stage beside the two component predictors. Execute-stage resolution drives the update port.

---
 rtl/tournament_chooser.sv | 176 +++++++++++++++++
 tb/tb_tournament_chooser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_chooser.sv
// ---------------------------------------------------------------------------
// tournament_chooser
//
// Chooser table for a tournament branch predictor. Each entry is a saturating
// counter that says whether predictor 1 (counter in the lower half) or
// predictor 2 (counter in the upper half) should be trusted for a branch.
// After reset a hardware sweep writes every entry to "weakly predictor 1"
// before any lookup or update is accepted.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   lookup_valid     fetch-stage lookup request
//   lookup_pc        branch word address (optionally hashed with history)
//   lookup_idx       registered index used by the lookup (carried to execute)
//   choice           registered choice: 1 = predictor 2, 0 = predictor 1
//   choice_valid     choice/lookup_idx valid, one cycle after the request
//   update_valid     resolved conditional branch
//   update_idx       index previously returned on lookup_idx
//   p1_correct       predictor 1 was correct
//   p2_correct       predictor 2 was correct
//   update_taken     branch outcome, shifted into global history
//   busy             initialisation sweep in progress
// ---------------------------------------------------------------------------
module tournament_chooser #(
    parameter int IDX_W    = 12,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 8,
    parameter int USE_HASH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_pc,
    output logic [IDX_W-1:0] lookup_idx,
    output logic             choice,
    output logic             choice_valid,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             p1_correct,
    input  logic             p2_correct,
    input  logic             update_taken,
    output logic             busy
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] WEAK_P1 = CTR_MAX >> 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HIST_W-1:0]  hist_q, hist_d;
    logic               choice_q, choice_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [CTR_W-1:0]   table_q [0:DEPTH-1];

    logic [IDX_W-1:0]   histExt;
    logic [IDX_W-1:0]   lookupIdx;
    logic [CTR_W-1:0]   curCtr;
    logic [CTR_W-1:0]   updCtr;
    logic               updChange;
    logic               wrEn;
    logic [IDX_W-1:0]   wrIdx;
    logic [CTR_W-1:0]   wrData;
    logic [CTR_W-1:0]   rdCtr;

    // Lookup index: pc, optionally XORed with the zero-extended history as it
    // stands before any shift happening this cycle.
    always_comb begin
        histExt = '0;
        histExt[HIST_W-1:0] = hist_q;
        if (USE_HASH != 0) begin
            lookupIdx = lookup_pc ^ histExt;
        end else begin
            lookupIdx = lookup_pc;
        end
    end

    // Saturating counter update. Agreement between the predictors (both right
    // or both wrong) carries no information, so no write is issued then.
    always_comb begin
        curCtr    = table_q[update_idx];
        updCtr    = curCtr;
        updChange = 1'b0;
        if (!p1_correct && p2_correct && (curCtr != CTR_MAX)) begin
            updCtr    = curCtr + CTR_W'(1);
            updChange = 1'b1;
        end else if (p1_correct && !p2_correct && (curCtr != '0)) begin
            updCtr    = curCtr - CTR_W'(1);
            updChange = 1'b1;
        end
    end

    // Next-state logic. The single write port is owned by the sweep in INIT
    // and by resolved updates in RUN. The lookup read is write-first: when an
    // update to the same entry lands this cycle, the new value is forwarded.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hist_d   = hist_q;
        choice_d = choice_q;
        valid_d  = 1'b0;
        idx_d    = idx_q;
        wrEn     = 1'b0;
        wrIdx    = update_idx;
        wrData   = updCtr;
        rdCtr    = table_q[lookupIdx];

        case (state_q)
            ST_INIT: begin
                wrEn   = 1'b1;
                wrIdx  = ptr_q;
                wrData = WEAK_P1;
                ptr_d  = ptr_q + IDX_W'(1);
                if (ptr_q == {IDX_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (update_valid) begin
                    wrEn   = updChange;
                    hist_d = HIST_W'({hist_q, update_taken});
                end
                if (wrEn && (wrIdx == lookupIdx)) begin
                    rdCtr = wrData;
                end
                if (lookup_valid) begin
                    valid_d  = 1'b1;
                    idx_d    = lookupIdx;
                    choice_d = rdCtr[CTR_W-1];
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control and output registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            ptr_q    <= '0;
            hist_q   <= '0;
            choice_q <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hist_q   <= hist_d;
            choice_q <= choice_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
        end
    end

    // Counter storage has no reset of its own; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            table_q[wrIdx] <= wrData;
        end
    end

    assign lookup_idx   = idx_q;
    assign choice       = choice_q;
    assign choice_valid = valid_q;
    assign busy         = (state_q == ST_INIT);

endmodule

// File: tb/tb_tournament_chooser.sv
// ---------------------------------------------------------------------------
// tb_tournament_chooser
//
// Directed testbench for a 16-entry, 2-bit, hashed chooser. Stimulus pushes
// the hand-computed lookup response into a queue; a monitor pops and compares
// whenever choice_valid is seen.
// ---------------------------------------------------------------------------
module tb_tournament_chooser;

    logic       clk;
    logic       rst_n;
    logic       lookup_valid;
    logic [3:0] lookup_pc;
    logic [3:0] lookup_idx;
    logic       choice;
    logic       choice_valid;
    logic       update_valid;
    logic [3:0] update_idx;
    logic       p1_correct;
    logic       p2_correct;
    logic       update_taken;
    logic       busy;

    typedef struct {
        logic [3:0] idx;
        logic       ch;
    } exp_t;

    exp_t expQ[$];
    int   testsRun;
    int   testsFailed;

    tournament_chooser #(
        .IDX_W   (4),
        .CTR_W   (2),
        .HIST_W  (4),
        .USE_HASH(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_valid(lookup_valid),
        .lookup_pc   (lookup_pc),
        .lookup_idx  (lookup_idx),
        .choice      (choice),
        .choice_valid(choice_valid),
        .update_valid(update_valid),
        .update_idx  (update_idx),
        .p1_correct  (p1_correct),
        .p2_correct  (p2_correct),
        .update_taken(update_taken),
        .busy        (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a wedged run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus; the expected lookup response is queued.
    task automatic applyStimulus(input bit lv, input logic [3:0] pc,
                                 input bit uv, input logic [3:0] uidx,
                                 input bit p1, input bit p2, input bit tk,
                                 input logic [3:0] eIdx, input bit eChoice);
        exp_t e;
        lookup_valid = lv;
        lookup_pc    = pc;
        update_valid = uv;
        update_idx   = uidx;
        p1_correct   = p1;
        p2_correct   = p2;
        update_taken = tk;
        if (lv) begin
            e.idx = eIdx;
            e.ch  = eChoice;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic lookupExpect(input logic [3:0] pc, input logic [3:0] eIdx, input bit eChoice);
        applyStimulus(1'b1, pc, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, eIdx, eChoice);
    endtask

    task automatic updateOnly(input logic [3:0] uidx, input bit p1, input bit p2, input bit tk);
        applyStimulus(1'b0, 4'd0, 1'b1, uidx, p1, p2, tk, 4'd0, 1'b0);
    endtask

    // Count cycles until busy drops, bounded
    task automatic waitSweep(input string name);
        int cycles;
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput(name, cycles, 16);
    endtask

    // Monitor: every presented choice must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (choice_valid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedValid: actual=1 required=0 (idx=%0d)", lookup_idx);
            end else begin
                e = expQ.pop_front();
                checkOutput("lookupIdx", int'(lookup_idx), int'(e.idx));
                checkOutput("choice", int'(choice), int'(e.ch));
            end
        end
    end

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        rst_n        = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        update_valid = 1'b0;
        update_idx   = '0;
        p1_correct   = 1'b0;
        p2_correct   = 1'b0;
        update_taken = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstChoice", int'(choice), 0);
        checkOutput("rstValid", int'(choice_valid), 0);
        checkOutput("rstIdx", int'(lookup_idx), 0);
        checkOutput("rstBusy", int'(busy), 1);

        // Sweep with requests held high; all must be ignored
        lookup_valid = 1'b1;
        lookup_pc    = 4'd0;
        update_valid = 1'b1;
        update_idx   = 4'd0;
        p2_correct   = 1'b1;
        update_taken = 1'b1;
        rst_n        = 1'b1;
        waitSweep("sweepLen1");
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        p2_correct   = 1'b0;
        update_taken = 1'b0;

        // Every entry starts weakly predictor 1, history still zero
        for (int i = 0; i < 16; i++) begin
            lookupExpect(4'(i), 4'(i), 1'b0);
        end

        // Saturating counter on entry 5 (history kept at zero with taken=0)
        updateOnly(4'd5, 1'b0, 1'b1, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b1);
        updateOnly(4'd5, 1'b0, 1'b1, 1'b0);
        updateOnly(4'd5, 1'b0, 1'b1, 1'b0);
        updateOnly(4'd5, 1'b0, 1'b1, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b1);
        updateOnly(4'd5, 1'b1, 1'b0, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b1);
        updateOnly(4'd5, 1'b1, 1'b0, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b0);
        updateOnly(4'd5, 1'b1, 1'b0, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b0);
        updateOnly(4'd5, 1'b1, 1'b0, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b0);
        updateOnly(4'd5, 1'b0, 1'b1, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b0);
        updateOnly(4'd5, 1'b0, 1'b1, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b1);

        // Agreement leaves entry 2 untouched
        updateOnly(4'd2, 1'b1, 1'b1, 1'b0);
        updateOnly(4'd2, 1'b0, 1'b0, 1'b0);
        lookupExpect(4'd2, 4'd2, 1'b0);
        updateOnly(4'd2, 1'b0, 1'b1, 1'b0);
        lookupExpect(4'd2, 4'd2, 1'b1);

        // Write-first bypass on entry 7 (1 -> 2)
        applyStimulus(1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1);

        // History 0101 after taken 1,0,1; same-cycle lookup hashes pre-shift
        updateOnly(4'd1, 1'b1, 1'b1, 1'b1);
        updateOnly(4'd1, 1'b1, 1'b1, 1'b0);
        updateOnly(4'd1, 1'b1, 1'b1, 1'b1);
        lookupExpect(4'b1111, 4'b1010, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0);
        lookupExpect(4'b1100, 4'b0111, 1'b1);

        // Reset mid-sweep after a prior update
        updateOnly(4'd3, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("midSweepBusy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst2Busy", int'(busy), 1);
        checkOutput("rst2Choice", int'(choice), 0);
        checkOutput("rst2Idx", int'(lookup_idx), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitSweep("sweepLen2");
        lookupExpect(4'd3, 4'd3, 1'b0);
        lookupExpect(4'd7, 4'd7, 1'b0);
        lookupExpect(4'd12, 4'd12, 1'b0);
        lookupExpect(4'd5, 4'd5, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queueDrained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
